// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 byte receiver.
// States, frame geometry and the default abort timeout.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int PS2_DATA_BITS       = 8;
   localparam int PS2_TIMEOUT_DEFAULT = 20000;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line plus a registered
// one-cycle strobe on each synchronized high-to-low transition.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic pin_in,
   output logic fall
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;
   logic fall_q, fall_d;

   // next values: shift the line through, flag 1->0 on the clean stages
   always_comb begin
      s1_d   = pin_in;
      s2_d   = s1_q;
      s3_d   = s2_q;
      fall_d = s3_q & ~s2_q;
   end

   // registers; reset to the bus-idle level so no false edge appears
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         s3_q   <= 1'b1;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         s3_q   <= s3_d;
         fall_q <= fall_d;
      end
   end

   assign fall = fall_q;

endmodule

// File: rtl/ps2_byte_rx.sv
// PS/2 device-to-host byte receiver: start, 8 data bits LSB first,
// odd parity, stop; registered result strobes and an inactivity abort.
module ps2_byte_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
   localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

   logic fall;

   ps2_sync_edge u_clk_sync (
      .clk   (clk),
      .reset (reset),
      .pin_in(ps2_clk),
      .fall  (fall)
   );

   rx_state_t     state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [CW-1:0] tmo_q, tmo_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic          perr_q, perr_d;
   logic          ferr_q, ferr_d;
   logic          busy_q, busy_d;
   logic          d1_q, d1_d;
   logic          d2_q, d2_d;
   logic          expired;

   // frame sequencing, sampling data only on clock-line fall strobes
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      par_ok_d = par_ok_q;
      byte_d   = byte_q;
      valid_d  = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      d1_d     = ps2_data;
      d2_d     = d1_q;
      expired  = (state_q != IDLE) && (tmo_q == TMO);

      if (state_q == IDLE || fall) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + CW'(1);
      end

      if (fall) begin
         case (state_q)
            IDLE: begin
               if (!d2_q) begin
                  state_d = DATA;
                  cnt_d   = 3'd0;
                  shift_d = 8'h00;
               end
            end
            DATA: begin
               shift_d = {d2_q, shift_q[7:1]};
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == LAST_BIT) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               par_ok_d = (^shift_q) ^ d2_q;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!d2_q) begin
                  ferr_d = 1'b1;
               end else if (par_ok_q) begin
                  valid_d = 1'b1;
                  byte_d  = shift_q;
               end else begin
                  perr_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (expired) begin
         state_d = IDLE;
         cnt_d   = 3'd0;
         ferr_d  = 1'b1;
      end

      busy_d = (state_d != IDLE);
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         tmo_q    <= '0;
         shift_q  <= 8'h00;
         par_ok_q <= 1'b0;
         byte_q   <= 8'h00;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         busy_q   <= 1'b0;
         d1_q     <= 1'b1;
         d2_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         shift_q  <= shift_d;
         par_ok_q <= par_ok_d;
         byte_q   <= byte_d;
         valid_q  <= valid_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         busy_q   <= busy_d;
         d1_q     <= d1_d;
         d2_q     <= d2_d;
      end
   end

   assign byte_out   = byte_q;
   assign byte_valid = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign busy       = busy_q;

endmodule
